// File: rtl/gcd_dispatch.sv
// Operand-pair FIFO feeding an external GCD engine, with a zero bypass,
// an engine watchdog and a held result port.
module gcd_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       eng_load,
  output logic [3:0] eng_x,
  output logic [3:0] eng_y,
  input  logic       eng_valid,
  input  logic [3:0] eng_gcd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_gcd,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic       out_err,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pair_t;

  pair_t          mem [FIFO_DEPTH];
  pair_t          head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     state;
  logic [7:0]     wait_cnt;
  logic           push;
  logic           pop;
  logic           head_zero;

  // Full blocks pushes even when a pop happens this cycle.
  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign head_zero = (head.x == 4'd0) || (head.y == 4'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{x: in_x, y: in_y};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      eng_load  <= 1'b0;
      eng_x     <= '0;
      eng_y     <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            out_x <= head.x;
            out_y <= head.y;
            busy  <= 1'b1;
            if (head_zero) begin
              // The OR yields the nonzero operand, or 0 when both are 0.
              out_gcd   <= head.x | head.y;
              out_err   <= (head.x | head.y) == 4'd0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              eng_x    <= head.x;
              eng_y    <= head.y;
              eng_load <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          eng_load <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (eng_valid) begin
            out_gcd   <= eng_gcd;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (wait_cnt == LAST) begin
            out_gcd   <= 4'd0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
